// File: rtl/line_clear_sequencer_pkg.sv
// Shared state encodings and default board dimensions for the line-clear sequencer.
package line_clear_sequencer_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } lcs_state_t;

  localparam int LCS_BOARD_W = 10;
  localparam int LCS_BOARD_H = 20;

endpackage

// File: rtl/line_clear_sequencer_row_remove.sv
// Combinational row deletion: rows above i_row drop by one, top row becomes empty.
module row_remove
  import line_clear_sequencer_pkg::*;
#(
  parameter int BOARD_W = LCS_BOARD_W,
  parameter int BOARD_H = LCS_BOARD_H
) (
  input  logic [BOARD_W*BOARD_H-1:0]   i_board,
  input  logic [$clog2(BOARD_H)-1:0]   i_row,
  output logic [BOARD_W*BOARD_H-1:0]   o_board
);

  localparam int ROW_W = $clog2(BOARD_H);

  for (genvar y = 0; y < BOARD_H; y++) begin : g_row
    if (y < BOARD_H - 1) begin : g_mid
      localparam logic [ROW_W-1:0] C_Y = ROW_W'(y);
      assign o_board[y*BOARD_W +: BOARD_W] = (i_row > C_Y) ? i_board[y*BOARD_W +: BOARD_W]
                                                           : i_board[(y+1)*BOARD_W +: BOARD_W];
    end else begin : g_top
      // Nothing can shift into the top row, and it is never below the removed row.
      assign o_board[y*BOARD_W +: BOARD_W] = '0;
    end
  end

endmodule

// File: rtl/line_clear_sequencer.sv
// Scans a placed board bottom-up, removes full rows one per cycle, and scores the pass.
// Optional macro LINE_CLEAR_STREAK_EN enables the consecutive-clear streak bonus.
module line_clear_sequencer
  import line_clear_sequencer_pkg::*;
#(
  parameter int BOARD_W = LCS_BOARD_W,
  parameter int BOARD_H = LCS_BOARD_H
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [BOARD_W*BOARD_H-1:0] board_in,
  input  logic                       streak_clr,
  output logic                       busy,
  output logic                       done,
  output logic [BOARD_W*BOARD_H-1:0] board_out,
  output logic [2:0]                 lines_cleared,
  output logic [4:0]                 score_add,
  output logic [1:0]                 streak
);

  localparam int                ROW_W    = $clog2(BOARD_H);
  localparam logic [ROW_W-1:0]  LAST_ROW = ROW_W'(BOARD_H - 1);

  lcs_state_t                 r_state;
  lcs_state_t                 w_state_nxt;
  logic [ROW_W-1:0]           r_row;
  logic [2:0]                 r_count;
  logic [BOARD_W*BOARD_H-1:0] r_board;
  logic [BOARD_W*BOARD_H-1:0] r_board_out;
  logic [2:0]                 r_lines;
  logic [4:0]                 r_score;
  logic [BOARD_W*BOARD_H-1:0] w_removed;
  logic                       w_row_full;
  logic [4:0]                 w_score;

  row_remove #(.BOARD_W(BOARD_W), .BOARD_H(BOARD_H)) u_row_remove (
    .i_board (r_board),
    .i_row   (r_row),
    .o_board (w_removed)
  );

  assign w_row_full = &r_board[int'(r_row)*BOARD_W +: BOARD_W];

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_SCAN;
      S_SCAN:  if (!w_row_full && (r_row == LAST_ROW)) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_row       <= '0;
      r_count     <= '0;
      r_board_out <= '0;
      r_lines     <= '0;
      r_score     <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_row   <= '0;
            r_count <= '0;
          end
        end
        S_SCAN: begin
          // A full row is removed in place, so the same index is re-examined next cycle.
          if (w_row_full) begin
            if (r_count != 3'd7) r_count <= r_count + 3'd1;
          end else if (r_row != LAST_ROW) begin
            r_row <= r_row + ROW_W'(1);
          end
        end
        S_DONE: begin
          r_board_out <= r_board;
          r_lines     <= r_count;
          r_score     <= w_score;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if ((r_state == S_IDLE) && start) r_board <= board_in;
    else if ((r_state == S_SCAN) && w_row_full) r_board <= w_removed;
  end

`ifdef LINE_CLEAR_STREAK_EN
  logic [1:0] r_streak;

  always_ff @(posedge clk) begin
    if (rst || streak_clr) begin
      r_streak <= '0;
    end else if (r_state == S_DONE) begin
      if (r_count == 3'd0)      r_streak <= 2'd0;
      else if (r_streak != 2'd3) r_streak <= r_streak + 2'd1;
    end
  end

  assign w_score = {2'b00, r_count} + {3'b000, r_streak};
  assign streak  = r_streak;
`else
  logic w_unused_streak_clr;
  assign w_unused_streak_clr = streak_clr;
  assign w_score = {2'b00, r_count};
  assign streak  = 2'b00;
`endif

  assign busy          = (r_state == S_SCAN);
  assign done          = (r_state == S_DONE);
  assign board_out     = r_board_out;
  assign lines_cleared = r_lines;
  assign score_add     = r_score;

endmodule

// File: tb/tb_line_clear_sequencer.sv
// Directed bench for line_clear_sequencer with a queued reference model of each pass.
module tb_line_clear_sequencer;

  localparam int BW = 10;
  localparam int BH = 20;
  localparam int N  = BW * BH;
`ifdef LINE_CLEAR_STREAK_EN
  localparam bit STREAK_EN = 1'b1;
`else
  localparam bit STREAK_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [N-1:0] board_in;
  logic         streak_clr;
  logic         busy;
  logic         done;
  logic [N-1:0] board_out;
  logic [2:0]   lines_cleared;
  logic [4:0]   score_add;
  logic [1:0]   streak;

  line_clear_sequencer #(.BOARD_W(BW), .BOARD_H(BH)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .board_in      (board_in),
    .streak_clr    (streak_clr),
    .busy          (busy),
    .done          (done),
    .board_out     (board_out),
    .lines_cleared (lines_cleared),
    .score_add     (score_add),
    .streak        (streak)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] board;
    int           lines;
    int           score;
    int           streak;
    int           scan;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  int   m_streak = 0;
  int   m_score  = 0;

  task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    n_chk++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: keep the non-full rows in order and pack them toward the bottom.
  function automatic void model(input logic [N-1:0] b, output logic [N-1:0] ob, output int k);
    int           dst;
    logic [BW-1:0] r;
    dst = 0;
    ob  = '0;
    k   = 0;
    for (int y = 0; y < BH; y++) begin
      r = b[y*BW +: BW];
      if (&r) k++;
      else begin
        ob[dst*BW +: BW] = r;
        dst++;
      end
    end
  endfunction

  task automatic run_pass(input string tag, input logic [N-1:0] b, input bit clr, input bit mid_start);
    exp_t         e;
    logic [N-1:0] eb;
    int           k, cyc, scan, nb;
    bit           seen;
    model(b, eb, k);
    e.board  = eb;
    e.lines  = (k > 7) ? 7 : k;
    e.scan   = BH + k;
    e.score  = e.lines + (STREAK_EN ? m_streak : 0);
    if (!STREAK_EN || clr || e.lines == 0) m_streak = 0;
    else m_streak = (m_streak == 3) ? 3 : m_streak + 1;
    e.streak = m_streak;
    m_score  = e.score;
    q.push_back(e);

    board_in = b;
    start    = 1'b1;
    tick();
    start = 1'b0;
    cyc   = 1;
    scan  = 0;
    seen  = 1'b0;
    while (!seen && cyc <= 200) begin
      if (done) seen = 1'b1;
      else begin
        if (busy) scan++;
        if (mid_start && cyc == 3) begin
          start    = 1'b1;
          board_in = ~b;
        end else start = 1'b0;
        tick();
        cyc++;
      end
    end
    start = 1'b0;
    check({tag, ":done_seen"}, N'(seen), N'(1));
    check({tag, ":scan_cycles"}, N'(scan), N'(e.scan));
    check({tag, ":done_cycle"}, N'(cyc), N'(e.scan + 1));

    streak_clr = clr;
    tick();
    streak_clr = 1'b0;
    check({tag, ":done_one_cycle"}, N'({done, busy}), N'(0));
    if (q.size() > 0) begin
      e = q.pop_front();
      check({tag, ":board_out"}, board_out, e.board);
      check({tag, ":lines"}, N'(lines_cleared), N'(e.lines));
      check({tag, ":score"}, N'(score_add), N'(e.score));
      check({tag, ":streak"}, N'(streak), N'(e.streak));
    end

    if (mid_start) begin
      nb = 0;
      repeat (30) begin
        tick();
        if (busy || done) nb++;
      end
      check({tag, ":no_second_pass"}, N'(nb), N'(0));
    end
  endtask

  task automatic clear_streak(input string tag);
    streak_clr = 1'b1;
    tick();
    streak_clr = 1'b0;
    m_streak = 0;
    check({tag, ":streak"}, N'(streak), N'(0));
    check({tag, ":score_kept"}, N'(score_add), N'(m_score));
  endtask

  function automatic logic [N-1:0] rand_board(input int pct_full);
    logic [N-1:0]  b;
    logic [BW-1:0] r;
    b = '0;
    for (int y = 0; y < BH; y++) begin
      if ($urandom_range(99) < pct_full) r = '1;
      else begin
        r = BW'($urandom);
        r[$urandom_range(BW-1)] = 1'b0;
      end
      b[y*BW +: BW] = r;
    end
    return b;
  endfunction

  logic [N-1:0] b_two, b_one, b_none, b_top, b_tmp;
  int           nd;

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    board_in   = '0;
    streak_clr = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check("rst:busy", N'(busy), N'(0));
    check("rst:done", N'(done), N'(0));
    check("rst:board_out", board_out, '0);
    check("rst:lines", N'(lines_cleared), N'(0));
    check("rst:score", N'(score_add), N'(0));
    check("rst:streak", N'(streak), N'(0));

    run_pass("empty", '0, 1'b0, 1'b0);

    b_two = '0;
    b_two[2*BW-1:0] = '1;
    b_two[2*BW+3]   = 1'b1;
    run_pass("two_rows", b_two, 1'b0, 1'b0);
    check("two_rows:only_cell_3_0", board_out, N'(8));

    clear_streak("clr_idle");
    for (int i = 0; i < 4; i++) begin
      b_one = '0;
      b_one[BW-1:0] = '1;
      b_one[3*BW + i] = 1'b1;
      run_pass($sformatf("single%0d", i), b_one, 1'b0, 1'b0);
    end

    clear_streak("clr_idle2");
    run_pass("streak_up_a", b_one, 1'b0, 1'b0);
    run_pass("streak_up_b", b_one, 1'b0, 1'b0);
    b_none = rand_board(0);
    run_pass("no_full", b_none, 1'b0, 1'b0);
    run_pass("streak_up_c", b_one, 1'b0, 1'b0);
    run_pass("clr_on_done", b_one, 1'b1, 1'b0);

    run_pass("full_board", '1, 1'b0, 1'b0);

    b_top = '0;
    b_top[(BH-1)*BW +: BW] = '1;
    b_top[0] = 1'b1;
    run_pass("top_row", b_top, 1'b0, 1'b0);

    // Abandon a pass at SCAN cycle 5.
    board_in = rand_board(30);
    start    = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    check("rst_mid:busy_before", N'(busy), N'(1));
    rst   = 1'b1;
    start = 1'b1;
    tick();
    rst   = 1'b0;
    start = 1'b0;
    m_streak = 0;
    m_score  = 0;
    check("rst_mid:busy", N'(busy), N'(0));
    check("rst_mid:done", N'(done), N'(0));
    check("rst_mid:board_out", board_out, '0);
    check("rst_mid:lines", N'(lines_cleared), N'(0));
    check("rst_mid:score", N'(score_add), N'(0));
    check("rst_mid:streak", N'(streak), N'(0));
    nd = 0;
    repeat (30) begin
      tick();
      if (done || busy) nd++;
    end
    check("rst_mid:no_done", N'(nd), N'(0));

    run_pass("mid_start", b_two, 1'b0, 1'b1);

    for (int i = 0; i < 4; i++) begin
      b_tmp = rand_board(35);
      run_pass($sformatf("rand%0d", i), b_tmp, 1'b0, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/line_clear_sequencer.md
LINE_CLEAR_SEQUENCER -- requirements
Module: line_clear_sequencer

Interface
REQ-001 SHALL have parameter BOARD_W, default 10, board width in cells.
REQ-002 SHALL have parameter BOARD_H, default 20, board height in rows; cell (x,y) is bit y*BOARD_W+x, with y=0 as the bottom row.
REQ-003 SHALL have port clk, input, 1 bit: single clock for all state.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port start, input, 1 bit: request a clear pass on board_in.
REQ-006 SHALL have port board_in, input, BOARD_W*BOARD_H bits: board after brick placement.
REQ-007 SHALL have port streak_clr, input, 1 bit: game-over streak reset.
REQ-008 SHALL have port busy, output, 1 bit: pass in progress.
REQ-009 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-010 SHALL have port board_out, output, BOARD_W*BOARD_H bits: cleared board.
REQ-011 SHALL have port lines_cleared, output, 3 bits: full rows removed in the last pass.
REQ-012 SHALL have port score_add, output, 5 bits: score increment for the last pass.
REQ-013 SHALL have port streak, output, 2 bits: current consecutive-clear streak.

Function
REQ-014 SHALL implement states IDLE, SCAN and DONE; busy SHALL be 1 exactly in SCAN.
REQ-015 In IDLE, start=1 SHALL latch board_in into the working board, set row=0 and count=0, and go to SCAN; start SHALL be ignored in SCAN and DONE.
REQ-016 SCAN, row full (all BOARD_W bits of the row set): rows above SHALL shift down by one, the top row SHALL become 0, count SHALL increment (saturating at 7), and row SHALL hold.
REQ-017 SCAN, row not full: row SHALL increment by 1; when row = BOARD_H-1, the next state SHALL be DONE.
REQ-018 A pass with k full rows SHALL spend exactly BOARD_H+k cycles in SCAN; done SHALL be high for the single following cycle, followed by a return to IDLE.
REQ-019 In the DONE cycle, board_out, lines_cleared=count and score_add=count+streak_old SHALL register, and streak SHALL update to 0 if count=0, else to min(streak_old+1,3).
REQ-020 board_out, lines_cleared and score_add SHALL hold their values until the next DONE cycle.
REQ-021 An empty board or a board with no full rows SHALL complete with board_out=board_in, lines_cleared=0 and score_add=streak_old.
REQ-022 A fully filled board SHALL complete with board_out=0, lines_cleared=min(BOARD_H,7) and BOARD_H+BOARD_H cycles in SCAN.
REQ-023 streak_clr=1 SHALL force streak to 0 on the next edge in any state, overriding the DONE-cycle update; it SHALL not affect the other outputs.
REQ-024 score_add SHALL be computed at 5-bit width and cannot overflow (7+3<32).

Reset
REQ-025 On rst=1 at a clk edge: state=IDLE, busy=0, done=0, board_out=0, lines_cleared=0, score_add=0, streak=0, row=0, count=0.
REQ-026 A reset asserted mid-SCAN SHALL abandon the pass without producing a done pulse; rst SHALL take priority over start.

Configuration
REQ-027 With the macro LINE_CLEAR_STREAK_EN defined, the streak behaviour of REQ-019 and REQ-023 SHALL apply.
REQ-028 Without LINE_CLEAR_STREAK_EN, the streak output SHALL be constant 0, score_add SHALL equal lines_cleared, and streak_clr SHALL be ignored.

Structure
REQ-029 The shared header SHALL hold the state encodings (IDLE, SCAN, DONE) and the board-dimension constants used as parameter defaults.
REQ-030 A combinational sub-module row_remove SHALL take a board and a row index and return the board with that row deleted, the rows above shifted down and the top row zeroed; the sequencer SHALL instantiate it once.

Verification
REQ-031 Empty board, start pulse -> done exactly 21 cycles after the start edge, board_out=0, lines_cleared=0, score_add=0, streak=0.
REQ-032 Rows 0 and 1 full, cell (3,2) set, streak=0 -> 22 SCAN cycles, board_out has only cell (3,0) set, lines_cleared=2, score_add=2, streak=1.
REQ-033 Four consecutive single-line passes -> score_add of 1, 2, 3, 4 and streak of 1, 2, 3, 3.
REQ-034 With streak=2, a pass with no full rows -> score_add=2 and streak=0; a pass with streak_clr asserted on the DONE cycle -> streak=0.
REQ-035 Reset asserted at SCAN cycle 5 -> busy=0 on the next cycle, no done pulse, all outputs 0; start pulsed during SCAN -> ignored and no second pass.
REQ-036 Build without LINE_CLEAR_STREAK_EN, repeating the REQ-033 sequence -> score_add=1 every pass and streak=0 throughout.
